// File: rtl/layer_1_pool_if.sv
`default_nettype none
// ============================================================================
// Module : layer_1_pool_if
// Brief  : Sample stream, frame clear, pooled read port and status of the
//          layer-1 pooling stage.
// Rev    : 1.0  initial release
// ============================================================================
interface layer_1_pool_if #(
  parameter int AW = 8,
  parameter int DW = 18
);
  logic          tx_done;
  logic          din_vld;
  logic [DW-1:0] din_0;
  logic [DW-1:0] din_1;
  logic [AW-1:0] addr_rd;
  logic [DW-1:0] dout_0;
  logic [DW-1:0] dout_1;
  logic [AW-1:0] wr_cnt;
  logic          done;
  logic          ovf;

  modport master (
    output tx_done, din_vld, din_0, din_1, addr_rd,
    input  dout_0, dout_1, wr_cnt, done, ovf
  );

  modport slave (
    input  tx_done, din_vld, din_0, din_1, addr_rd,
    output dout_0, dout_1, wr_cnt, done, ovf
  );
endinterface
`default_nettype wire

// File: rtl/layer_1_pool.sv
`default_nettype none
// ============================================================================
// Module : layer_1_pool
// Brief  : 2x2 pooling of two 18-bit channels into a 169-entry buffer per
//          channel. Max pooling by default; average pooling when the macro
//          L1_AVG_POOL_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
module layer_1_pool #(
  parameter int DEPTH = 169,
  parameter int AW    = 8,
  parameter int DW    = 18
) (
  input  logic           clk,
  input  logic           rst_n,
  layer_1_pool_if.slave  bus
);

`ifdef L1_AVG_POOL_EN
  localparam int ACCW = DW + 2;
`else
  localparam int ACCW = DW;
`endif

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [1:0]    state_q, state_d;
  logic [1:0]    smp_q, smp_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic          ovf_q, ovf_d;

  logic          w_take;
  logic          w_load;
  logic          w_acc_en;
  logic          w_wr;

  logic [DW-1:0] w_din  [2];
  logic [DW-1:0] w_dout [2];

  // tx_done outranks din_vld: a sample arriving with the clear is lost
  assign w_take   = bus.din_vld & ~bus.tx_done;
  assign w_load   = w_take & (state_q == ST_IDLE);
  assign w_acc_en = w_take & (state_q == ST_ACC);
  assign w_wr     = w_acc_en & (smp_q == 2'd3);

  assign w_din[0] = bus.din_0;
  assign w_din[1] = bus.din_1;

  always_comb begin
    state_d  = state_q;
    smp_d    = smp_q;
    wr_cnt_d = wr_cnt_q;
    ovf_d    = ovf_q;
    if (bus.tx_done) begin
      state_d  = ST_IDLE;
      smp_d    = 2'd0;
      wr_cnt_d = '0;
      ovf_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.din_vld) begin
            smp_d   = 2'd1;
            state_d = ST_ACC;
          end
        end
        ST_ACC: begin
          if (bus.din_vld) begin
            if (smp_q == 2'd3) begin
              smp_d    = 2'd0;
              wr_cnt_d = wr_cnt_q + 1'b1;
              state_d  = (wr_cnt_q == LAST_ADDR) ? ST_FULL : ST_IDLE;
            end else begin
              smp_d = smp_q + 1'b1;
            end
          end
        end
        ST_FULL: begin
          if (bus.din_vld) begin
            ovf_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      smp_q    <= 2'd0;
      wr_cnt_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      smp_q    <= smp_d;
      wr_cnt_q <= wr_cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic [ACCW-1:0] acc_q;
    logic [ACCW-1:0] w_comb;
    logic [DW-1:0]   w_wdata;
    logic [DW-1:0]   mem_q [DEPTH];
    logic [DW-1:0]   rd_q;

`ifdef L1_AVG_POOL_EN
    assign w_comb  = acc_q + ACCW'(w_din[ch]);
    assign w_wdata = DW'(w_comb >> 2);
`else
    assign w_comb  = (ACCW'(w_din[ch]) > acc_q) ? ACCW'(w_din[ch]) : acc_q;
    assign w_wdata = DW'(w_comb);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_q <= '0;
      end else if (w_load) begin
        acc_q <= ACCW'(w_din[ch]);
      end else if (w_acc_en) begin
        acc_q <= w_comb;
      end
    end

    // Write and read share the edge; the read sees the pre-write contents
    always_ff @(posedge clk) begin
      if (w_wr) begin
        mem_q[wr_cnt_q] <= w_wdata;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_q <= '0;
      end else begin
        rd_q <= mem_q[bus.addr_rd];
      end
    end

    assign w_dout[ch] = rd_q;
  end

  assign bus.dout_0 = w_dout[0];
  assign bus.dout_1 = w_dout[1];
  assign bus.wr_cnt = wr_cnt_q;
  assign bus.done   = (state_q == ST_FULL);
  assign bus.ovf    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_layer_1_pool.sv
`default_nettype none
// ============================================================================
// Module : tb_layer_1_pool
// Brief  : Table vectors, directed corner sequences and randomized traffic
//          for layer_1_pool, checked against a queue-based pooling model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_layer_1_pool;

  localparam int DEPTH = 169;

`ifdef L1_AVG_POOL_EN
  localparam int A0 = 6, A1 = 0, C0 = 2, C1 = 2, R0 = 12;
`else
  localparam int A0 = 9, A1 = 2, C0 = 4, C1 = 4, R0 = 14;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  layer_1_pool_if #(.AW(8), .DW(18)) bus ();

  layer_1_pool #(.DEPTH(DEPTH), .AW(8), .DW(18)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int pass_cnt = 0;
  int tot_cnt  = 0;

  // Reference: samples queue up per window; the 4th one produces an entry
  logic [17:0] m0 [DEPTH];
  logic [17:0] m1 [DEPTH];
  bit          mv [DEPTH];
  int          mcnt = 0;
  bit          movf = 1'b0;
  logic [17:0] q0 [$];
  logic [17:0] q1 [$];

  typedef struct {
    bit vld; bit txd; int d0; int d1; int cnt; bit rd; int e0; int e1;
  } vec_t;
  vec_t tbl [$];

  function automatic logic [17:0] pool4(input logic [17:0] a, b, c, d);
`ifdef L1_AVG_POOL_EN
    return 18'((int'(a) + int'(b) + int'(c) + int'(d)) / 4);
`else
    logic [17:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
`endif
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tot_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    mcnt = 0;
    movf = 1'b0;
    q0.delete();
    q1.delete();
  endtask

  task automatic cyc(input bit vld, input int d0, input int d1, input bit txd);
    int a;
    bit ev;
    logic [17:0] e0, e1;
    bus.din_vld = vld;
    bus.din_0   = 18'(d0);
    bus.din_1   = 18'(d1);
    bus.tx_done = txd;
    a  = int'(bus.addr_rd);
    ev = (a < DEPTH) && mv[a];
    e0 = (a < DEPTH) ? m0[a] : '0;
    e1 = (a < DEPTH) ? m1[a] : '0;
    @(posedge clk);
    if (txd) begin
      model_reset();
    end else if (vld) begin
      if (mcnt == DEPTH) begin
        movf = 1'b1;
      end else begin
        q0.push_back(18'(d0));
        q1.push_back(18'(d1));
        if (q0.size() == 4) begin
          m0[mcnt] = pool4(q0[0], q0[1], q0[2], q0[3]);
          m1[mcnt] = pool4(q1[0], q1[1], q1[2], q1[3]);
          mv[mcnt] = 1'b1;
          mcnt++;
          q0.delete();
          q1.delete();
        end
      end
    end
    #1;
    bus.din_vld = 1'b0;
    bus.tx_done = 1'b0;
    chk("wr_cnt", int'(bus.wr_cnt), mcnt);
    chk("done", int'(bus.done), int'(mcnt == DEPTH));
    chk("ovf", int'(bus.ovf), int'(movf));
    if (ev) begin
      chk("dout_0", int'(bus.dout_0), int'(e0));
      chk("dout_1", int'(bus.dout_1), int'(e1));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wr_cnt"}, int'(bus.wr_cnt), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_ovf"}, int'(bus.ovf), 0);
    chk({tag, "_dout_0"}, int'(bus.dout_0), 0);
    chk({tag, "_dout_1"}, int'(bus.dout_1), 0);
  endtask

  initial begin
    bit v, t;
    int a, b;
    bus.din_vld = 1'b0;
    bus.tx_done = 1'b0;
    bus.din_0   = '0;
    bus.din_1   = '0;
    bus.addr_rd = '0;
    for (int i = 0; i < DEPTH; i++) mv[i] = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;

    // {vld, txd, d0, d1, cnt, rd, e0, e1}
    tbl.push_back('{1, 0, 5, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 9, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 3, 2, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 7, 1, 1, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 1, 1, A0, A1});
    tbl.push_back('{0, 1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 5, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 9, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 3, 2, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 7, 1, 1, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 1, 1, A0, A1});
    tbl.push_back('{0, 1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 7, 7, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 7, 7, 0, 0, 0, 0});
    tbl.push_back('{1, 1, 100, 100, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 1, 4, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 2, 3, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 3, 2, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 4, 1, 1, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 1, 1, C0, C1});
    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].vld, tbl[i].d0, tbl[i].d1, tbl[i].txd);
      chk($sformatf("tbl%0d_cnt", i), int'(bus.wr_cnt), tbl[i].cnt);
      chk($sformatf("tbl%0d_ovf", i), int'(bus.ovf), 0);
      if (tbl[i].rd) begin
        chk($sformatf("tbl%0d_e0", i), int'(bus.dout_0), tbl[i].e0);
        chk($sformatf("tbl%0d_e1", i), int'(bus.dout_1), tbl[i].e1);
      end
    end

    // Full frame of 169 windows, then read every entry back
    cyc(0, 0, 0, 1);
    for (int k = 0; k < DEPTH; k++)
      for (int s = 0; s < 4; s++) cyc(1, k, 3 * k, 0);
    chk("fill_done", int'(bus.done), 1);
    chk("fill_cnt", int'(bus.wr_cnt), DEPTH);
    for (int k = 0; k < DEPTH; k++) begin
      bus.addr_rd = 8'(k);
      cyc(0, 0, 0, 0);
      chk($sformatf("fill_rd%0d", k), int'(bus.dout_0), k);
    end

    // Samples after done are ignored and raise ovf
    for (int s = 0; s < 4; s++) cyc(1, 18'h3FFFF, 18'h3FFFF, 0);
    chk("ovf_set", int'(bus.ovf), 1);
    chk("ovf_cnt", int'(bus.wr_cnt), DEPTH);
    bus.addr_rd = 8'd168;
    cyc(0, 0, 0, 0);
    chk("ovf_e168", int'(bus.dout_0), 168);

    // Read of the address being written returns old data, new one after
    cyc(0, 0, 0, 1);
    bus.addr_rd = 8'd0;
    for (int s = 0; s < 4; s++) cyc(1, 50000, 60000, 0);
    chk("rw_old", int'(bus.dout_0), 0);
    cyc(0, 0, 0, 0);
    chk("rw_new", int'(bus.dout_0), 50000);

    // Async reset mid-window: partial window at address 1 never written
    bus.addr_rd = 8'd1;
    cyc(1, 777, 888, 0);
    cyc(1, 777, 888, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero("arst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    cyc(0, 0, 0, 0);
    chk("arst_e1", int'(bus.dout_0), 1);
    bus.addr_rd = 8'd0;
    cyc(1, 11, 11, 0);
    cyc(1, 12, 12, 0);
    cyc(1, 13, 13, 0);
    cyc(1, 14, 14, 0);
    chk("arst_cnt", int'(bus.wr_cnt), 1);
    cyc(0, 0, 0, 0);
    chk("arst_e0", int'(bus.dout_0), R0);

    // Randomized traffic: gaps, small values for ties, rare frame clears
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 9) < 8);
      t = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 3) == 0) begin
        a = int'($urandom_range(0, 3));
        b = int'($urandom_range(0, 3));
      end else begin
        a = int'($urandom & 32'h3FFFF);
        b = int'($urandom & 32'h3FFFF);
      end
      bus.addr_rd = 8'($urandom_range(0, DEPTH - 1));
      cyc(v, a, b, t);
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
`default_nettype wire
